// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-master round-robin arbiter/sequencer for one single-port SRAM
//
// Purpose: grants one SRAM access per cycle to instruction-fetch master M0 or
// load/store master M1, drives the SRAM control pins during the granted cycle,
// and returns registered read data to the master that issued the read.
//
// Ports:
//   CLK, RST                  clock (posedge), synchronous active-high reset
//   Mx_REQ/WE/ADDR/BE/DI      master x request and command fields (x = 0, 1)
//   Mx_GNT                    one-cycle pulse: request consumed, SRAM access this cycle
//   Mx_RVALID/RDATA           one-cycle read-data-valid pulse, data held until next read
//   SRAM_CSN/WEN              active-low chip select / write enable
//   SRAM_ADDR/BE/DI           SRAM address, byte enables, write data
//   SRAM_DOUT                 SRAM asynchronous read data
//
// Optional build macro: SRAM_ARB_FIXED_PRIO_EN
//   defined   -> M0 wins every conflict (M1 may starve)
//   undefined -> round-robin on conflicts

module sram_port_arbiter #(
    parameter int AWIDTH = 12
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              M0_REQ,
    input  logic              M0_WE,
    input  logic [AWIDTH-1:0] M0_ADDR,
    input  logic [3:0]        M0_BE,
    input  logic [31:0]       M0_DI,
    output logic              M0_GNT,
    output logic              M0_RVALID,
    output logic [31:0]       M0_RDATA,

    input  logic              M1_REQ,
    input  logic              M1_WE,
    input  logic [AWIDTH-1:0] M1_ADDR,
    input  logic [3:0]        M1_BE,
    input  logic [31:0]       M1_DI,
    output logic              M1_GNT,
    output logic              M1_RVALID,
    output logic [31:0]       M1_RDATA,

    output logic              SRAM_CSN,
    output logic              SRAM_WEN,
    output logic [AWIDTH-1:0] SRAM_ADDR,
    output logic [3:0]        SRAM_BE,
    output logic [31:0]       SRAM_DI,
    input  logic [31:0]       SRAM_DOUT
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Command register: the access being performed while in ACCESS.
    logic              cmd_we;
    logic [AWIDTH-1:0] cmd_addr;
    logic [3:0]        cmd_be;
    logic [31:0]       cmd_di;
    logic              owner;
    logic              last;

    logic              rvalid0;
    logic              rvalid1;
    logic [31:0]       rdata0;
    logic [31:0]       rdata1;

    logic              elig0;
    logic              elig1;
    logic              grant_any;
    logic              winner;
    logic              win_we;
    logic [AWIDTH-1:0] win_addr;
    logic [3:0]        win_be;
    logic [31:0]       win_di;

    // Next-state, arbitration and output decode.
    always_comb begin
        state_nxt = IDLE;
        winner    = 1'b0;
        win_we    = M0_WE;
        win_addr  = M0_ADDR;
        win_be    = M0_BE;
        win_di    = M0_DI;

        // The owner still holds REQ during its GNT cycle; mask it so the
        // same request is not granted twice.
        elig0     = M0_REQ && !(state == ACCESS && owner == 1'b0);
        elig1     = M1_REQ && !(state == ACCESS && owner == 1'b1);
        grant_any = elig0 || elig1;

`ifdef SRAM_ARB_FIXED_PRIO_EN
        winner = !elig0;
`else
        if (elig0 && elig1) begin
            winner = ~last;
        end else begin
            winner = elig1;
        end
`endif

        if (winner) begin
            win_we   = M1_WE;
            win_addr = M1_ADDR;
            win_be   = M1_BE;
            win_di   = M1_DI;
        end

        if (grant_any) begin
            state_nxt = ACCESS;
        end
    end

    // SRAM pins sit at their idle values unless an access is in flight.
    always_comb begin
        SRAM_CSN  = 1'b1;
        SRAM_WEN  = 1'b1;
        SRAM_ADDR = '0;
        SRAM_BE   = '0;
        SRAM_DI   = '0;
        M0_GNT    = 1'b0;
        M1_GNT    = 1'b0;
        if (state == ACCESS) begin
            SRAM_CSN  = 1'b0;
            SRAM_WEN  = ~cmd_we;
            SRAM_ADDR = cmd_addr;
            SRAM_BE   = cmd_be;
            SRAM_DI   = cmd_di;
            M0_GNT    = (owner == 1'b0);
            M1_GNT    = (owner == 1'b1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            last     <= 1'b1;
            owner    <= 1'b0;
            cmd_we   <= 1'b0;
            cmd_addr <= '0;
            cmd_be   <= '0;
            cmd_di   <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            state <= state_nxt;
            if (grant_any) begin
                cmd_we   <= win_we;
                cmd_addr <= win_addr;
                cmd_be   <= win_be;
                cmd_di   <= win_di;
                owner    <= winner;
                last     <= winner;
            end

            // Read data is captured at the edge closing the ACCESS cycle;
            // the SRAM read path is asynchronous so SRAM_DOUT is settled.
            rvalid0 <= (state == ACCESS) && !cmd_we && (owner == 1'b0);
            rvalid1 <= (state == ACCESS) && !cmd_we && (owner == 1'b1);
            if (state == ACCESS && !cmd_we) begin
                if (owner == 1'b0) begin
                    rdata0 <= SRAM_DOUT;
                end else begin
                    rdata1 <= SRAM_DOUT;
                end
            end
        end
    end

    assign M0_RVALID = rvalid0;
    assign M1_RVALID = rvalid1;
    assign M0_RDATA  = rdata0;
    assign M1_RDATA  = rdata1;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - randomized self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

    localparam int AW = 12;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req  [2];
    logic          we   [2];
    logic [AW-1:0] addr [2];
    logic [3:0]    be   [2];
    logic [31:0]   di   [2];

    logic          M0_GNT, M0_RVALID, M1_GNT, M1_RVALID;
    logic [31:0]   M0_RDATA, M1_RDATA;
    logic          SRAM_CSN, SRAM_WEN;
    logic [AW-1:0] SRAM_ADDR;
    logic [3:0]    SRAM_BE;
    logic [31:0]   SRAM_DI, SRAM_DOUT;

    int n_checks = 0;
    int n_errors = 0;

    sram_port_arbiter #(.AWIDTH(AW)) dut (
        .CLK(CLK), .RST(RST),
        .M0_REQ(req[0]), .M0_WE(we[0]), .M0_ADDR(addr[0]), .M0_BE(be[0]), .M0_DI(di[0]),
        .M0_GNT(M0_GNT), .M0_RVALID(M0_RVALID), .M0_RDATA(M0_RDATA),
        .M1_REQ(req[1]), .M1_WE(we[1]), .M1_ADDR(addr[1]), .M1_BE(be[1]), .M1_DI(di[1]),
        .M1_GNT(M1_GNT), .M1_RVALID(M1_RVALID), .M1_RDATA(M1_RDATA),
        .SRAM_CSN(SRAM_CSN), .SRAM_WEN(SRAM_WEN), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_BE(SRAM_BE), .SRAM_DI(SRAM_DI), .SRAM_DOUT(SRAM_DOUT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_val(input int i);
        return 32'(i) * 32'h9E37_79B9;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] bes);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (bes[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // SRAM environment: negedge write with byte enables, asynchronous read.
    logic [31:0] sram [0:4095];
    logic        sram_init = 1'b0;
    always @(negedge CLK) begin
        if (!sram_init) begin
            for (int i = 0; i < 4096; i++) sram[i] <= init_val(i);
            sram_init <= 1'b1;
        end else if (!SRAM_CSN && !SRAM_WEN) begin
            sram[SRAM_ADDR] <= merge(sram[SRAM_ADDR], SRAM_DI, SRAM_BE);
        end
    end
    assign SRAM_DOUT = sram[SRAM_ADDR];

    // Reference model: which master (if any) owns the current cycle, the
    // access it performs, the expected read responses and a memory image.
    int          owner_m = -1;
    int          last_m  = 1;
    logic        m_we;
    logic [AW-1:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_di;
    logic [31:0] ref_mem [0:4095];
    logic        exp_rv [2];
    logic [31:0] exp_rd [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the inputs the DUT sampled.
    task automatic model_step();
        int  win;
        bit  e [2];
        if (owner_m >= 0 && m_we) ref_mem[m_addr] = merge(ref_mem[m_addr], m_di, m_be);
        if (RST) begin
            owner_m = -1;
            last_m  = 1;
            for (int i = 0; i < 2; i++) begin exp_rv[i] = 0; exp_rd[i] = '0; end
            return;
        end
        for (int i = 0; i < 2; i++) exp_rv[i] = 0;
        if (owner_m >= 0 && !m_we) begin
            exp_rv[owner_m] = 1;
            exp_rd[owner_m] = ref_mem[m_addr];
        end
        for (int i = 0; i < 2; i++) e[i] = req[i] && (owner_m != i);
        win = -1;
        if (e[0] && e[1]) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            win = 0;
`else
            win = 1 - last_m;
`endif
        end else if (e[0]) win = 0;
        else if (e[1]) win = 1;
        if (win >= 0) begin
            m_we = we[win]; m_addr = addr[win]; m_be = be[win]; m_di = di[win];
            last_m = win;
        end
        owner_m = win;
    endtask

    task automatic check_outputs();
        bit act;
        act = (owner_m >= 0);
        check("m0_gnt",    32'(M0_GNT),    32'(owner_m == 0));
        check("m1_gnt",    32'(M1_GNT),    32'(owner_m == 1));
        check("sram_csn",  32'(SRAM_CSN),  32'(!act));
        check("sram_wen",  32'(SRAM_WEN),  32'(act ? !m_we : 1'b1));
        check("sram_addr", 32'(SRAM_ADDR), act ? 32'(m_addr) : 32'd0);
        check("sram_be",   32'(SRAM_BE),   act ? 32'(m_be) : 32'd0);
        check("sram_di",   SRAM_DI,        act ? m_di : 32'd0);
        check("m0_rvalid", 32'(M0_RVALID), 32'(exp_rv[0]));
        check("m1_rvalid", 32'(M1_RVALID), 32'(exp_rv[1]));
        check("m0_rdata",  M0_RDATA,       exp_rd[0]);
        check("m1_rdata",  M1_RDATA,       exp_rd[1]);
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        check_outputs();
    endtask

    // Present one request and hold it until the model grants it; returns in the GNT cycle.
    task automatic issue(input int m, input logic w, input logic [AW-1:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        bit got;
        we[m] = w; addr[m] = a; be[m] = b; di[m] = d; req[m] = 1'b1;
        got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            cycle();
            got = (owner_m == m);
        end
        if (!got) check("issue_timeout", 32'd0, 32'd1);
        req[m] = 1'b0;
    endtask

    initial begin
        int n1;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
        for (int i = 0; i < 2; i++) begin
            req[i] = 0; we[i] = 0; addr[i] = '0; be[i] = '0; di[i] = '0;
            exp_rv[i] = 0; exp_rd[i] = '0;
        end
        m_we = 0; m_addr = '0; m_be = '0; m_di = '0;

        // Reset, then idle.
        RST = 1'b1;
        cycle();
        cycle();
        RST = 1'b0;
        repeat (3) begin
            cycle();
            check("idle_csn", 32'(SRAM_CSN), 32'd1);
            check("idle_rdata1", M1_RDATA, 32'd0);
        end

        // M0 write, then read back.
        issue(0, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF);
        check("wr_gnt", 32'(M0_GNT), 32'd1);
        check("wr_wen", 32'(SRAM_WEN), 32'd0);
        issue(0, 1'b0, 12'h010, 4'h0, 32'h0);
        cycle();
        check("rd_rvalid", 32'(M0_RVALID), 32'd1);
        check("rd_data", M0_RDATA, 32'hDEADBEEF);

        // Partial write by M1.
        issue(1, 1'b1, 12'h020, 4'hF, 32'h11223344);
        issue(1, 1'b1, 12'h020, 4'h5, 32'hAABBCCDD);
        issue(1, 1'b0, 12'h020, 4'h0, 32'h0);
        cycle();
        check("pw_rvalid", 32'(M1_RVALID), 32'd1);
        check("pw_data", M1_RDATA, 32'h11BB33DD);

        // Conflict: both masters keep requesting reads.
        we[0] = 0; addr[0] = 12'h001; we[1] = 0; addr[1] = 12'h002;
        req[0] = 1; req[1] = 1;
        cycle();
        n1 = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("conf_csn", 32'(SRAM_CSN), 32'd0);
            n1 += int'(M1_GNT);
        end
        check("conf_m1_grants", 32'(n1), 32'd4);
        req[0] = 0; req[1] = 0;
        cycle();
        cycle();

        // Same master back-to-back: grants every other cycle.
        addr[0] = 12'h010;
        req[0] = 1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("b2b_gnt", 32'(M0_GNT), 32'((k % 2) == 0));
            check("b2b_csn", 32'(SRAM_CSN), 32'(k % 2));
        end
        req[0] = 0;
        cycle();
        cycle();

        // Reset while an M1 read is in ACCESS.
        issue(1, 1'b0, 12'h030, 4'h0, 32'h0);
        RST = 1;
        cycle();
        check("rst_rd_rvalid", 32'(M1_RVALID), 32'd0);
        check("rst_rd_csn", 32'(SRAM_CSN), 32'd1);
        RST = 0;
        cycle();
        check("rst_rd_rvalid2", 32'(M1_RVALID), 32'd0);

        // Reset while an M1 write is in ACCESS: the write is kept.
        issue(1, 1'b1, 12'h030, 4'hF, 32'h5A5A0330);
        RST = 1;
        cycle();
        RST = 0;
        cycle();
        issue(1, 1'b0, 12'h030, 4'h0, 32'h0);
        cycle();
        check("rst_wr_data", M1_RDATA, 32'h5A5A0330);

        // Random traffic with occasional resets.
        for (int k = 0; k < 800; k++) begin
            RST = ($urandom_range(0, 63) == 0);
            for (int m = 0; m < 2; m++) begin
                if (owner_m == m || !req[m]) begin
                    req[m]  = ($urandom_range(0, 2) != 0);
                    we[m]   = $urandom_range(0, 1);
                    addr[m] = AW'($urandom_range(0, 63));
                    be[m]   = 4'($urandom);
                    di[m]   = $urandom;
                end
            end
            cycle();
        end
        RST = 0;
        req[0] = 0;
        req[1] = 0;
        repeat (4) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
